// File: rtl/mem_arb_pkg.sv
// =============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and default widths for the I/D memory arbiter.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int c_DEF_LINE_W = 128;
    localparam int c_DEF_ADDR_W = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// =============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin pick between I and D.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   i_req_d,
    input  owner_t i_ptr,
    output logic   o_valid,
    output owner_t o_grant
);

    // The pointer only decides ties; a lone requester always wins.
    always_comb begin
        o_valid = i_req_i | i_req_d;
        o_grant = OWN_I;
        if (i_req_i && i_req_d) begin
            o_grant = i_ptr;
        end else if (i_req_d) begin
            o_grant = OWN_D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
// =============================================================================
//  Module      : imem_dmem_arbiter
//  Description : Serialises I-cache refills and D-cache refills/write-backs onto
//                one memory line port, round-robin, with a sticky timeout flag.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_W  = c_DEF_LINE_W,
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter bit FIRST_D = 1'b1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI,
    input  logic [ADDR_W-1:0] addrI,
    input  logic              reqD,
    input  logic              weD,
    input  logic [ADDR_W-1:0] addrD,
    input  logic [LINE_W-1:0] wdataD,
    output logic              readyI,
    output logic              readyD,
    output logic              ackD,
    output logic [LINE_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err
);

    localparam int                 c_CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    owner_t              r_rr_ptr;
    owner_t              r_owner;
    owner_t              w_grant;
    logic                w_grant_valid;
    logic                r_ready_i;
    logic                r_ready_d;
    logic                r_ack_d;
    logic [LINE_W-1:0]   r_rdata;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LINE_W-1:0]   r_mem_wdata;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                r_err;

    rr_arb2 u_rr_arb2 (
        .i_req_i (reqI),
        .i_req_d (reqD),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_grant_valid),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // RESP always falls through to IDLE, so a still-held request is not re-granted.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_grant_valid) w_state_next = ISSUE;
            ISSUE:   if (mem_ready)     w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr    <= FIRST_D ? OWN_D : OWN_I;
            r_owner     <= OWN_I;
            r_ready_i   <= 1'b0;
            r_ready_d   <= 1'b0;
            r_ack_d     <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_ready_i <= 1'b0;
            r_ready_d <= 1'b0;
            r_ack_d   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner     <= w_grant;
                        r_rr_ptr    <= (w_grant == OWN_D) ? OWN_I : OWN_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_grant == OWN_D) && weD;
                        r_mem_addr  <= (w_grant == OWN_D) ? addrD : addrI;
                        r_mem_wdata <= (w_grant == OWN_D) ? wdataD : '0;
                        r_cnt       <= '0;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_ready_i <= (r_owner == OWN_I);
                        r_ready_d <= (r_owner == OWN_D) && !r_mem_we;
                        r_ack_d   <= (r_owner == OWN_D) &&  r_mem_we;
                    end else begin
                        // Flag only; the transaction keeps waiting for memory.
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_CNT_MAX) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign readyI    = r_ready_i;
    assign readyD    = r_ready_d;
    assign ackD      = r_ack_d;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
// =============================================================================
//  Module      : tb_imem_dmem_arbiter
//  Description : Self-checking bench for imem_dmem_arbiter.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_imem_dmem_arbiter;

    localparam int LW = 128;
    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          reqI = 1'b0, reqD = 1'b0, weD = 1'b0;
    logic [AW-1:0] addrI = '0, addrD = '0;
    logic [LW-1:0] wdataD = '0, mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          readyI, readyD, ackD, mem_req, mem_we, busy, err;
    logic [LW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad   = 0;

    imem_dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .reqI      (reqI),
        .addrI     (addrI),
        .reqD      (reqD),
        .weD       (weD),
        .addrD     (addrD),
        .wdataD    (wdataD),
        .readyI    (readyI),
        .readyD    (readyD),
        .ackD      (ackD),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rI;
        logic          rD;
        logic          we;
        logic [AW-1:0] aI;
        logic [AW-1:0] aD;
        logic [LW-1:0] wd;
        logic [LW-1:0] md;
        int            dly;
        logic          e_own_d;
        logic [2:0]    e_pl;     // {ackD, readyD, readyI}
        logic [LW-1:0] e_rd;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random-phase model state, at transaction level
    logic          m_open, m_resp, m_last_d, m_own_d, m_we;
    int            m_wait;
    logic          e_req, e_we, e_busy;
    logic [2:0]    e_pl;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata, e_rdata;
    logic [AW-1:0] exp_order[3];

    initial begin
        tv[0] = '{1'b1, 1'b0, 1'b0, 26'h0000010, 26'h0, '0, {16{8'hA5}}, 4, 1'b0, 3'b001, {16{8'hA5}}};
        tv[1] = '{1'b0, 1'b1, 1'b1, 26'h0, 26'h3FFFFFF, {8{16'h1234}}, {16{8'hFF}}, 2, 1'b1, 3'b100, {16{8'hA5}}};
        tv[2] = '{1'b0, 1'b1, 1'b0, 26'h0, 26'h2AAAAAA, '0, {8{16'h5A5A}}, 1, 1'b1, 3'b010, {8{16'h5A5A}}};
        tv[3] = '{1'b1, 1'b1, 1'b0, 26'h1111111, 26'h2222222, '0, {16{8'hC3}}, 3, 1'b0, 3'b001, {16{8'hC3}}};
        tv[4] = '{1'b1, 1'b1, 1'b1, 26'h1234567, 26'h0765432, {4{32'hDEADBEEF}}, {16{8'h77}}, 2, 1'b1, 3'b100, {16{8'hC3}}};
        tv[5] = '{1'b1, 1'b0, 1'b0, 26'h0ABCDEF, 26'h0, '0, {16{8'h0F}}, 1, 1'b0, 3'b001, {16{8'h0F}}};

        // Reset held with both requests high
        reqI = 1'b1; reqD = 1'b1;
        step(); step();
        chk("rst.mem_req", mem_req, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        chk("rst.pulses", {ackD, readyD, readyI}, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.busy", busy, 0);
        chk("rst.err", err, 0);
        reqI = 1'b0; reqD = 1'b0; reset = 1'b1;
        step();

        // Single transactions from IDLE
        for (int i = 0; i < 6; i++) begin
            reqI = tv[i].rI; reqD = tv[i].rD; weD = tv[i].we;
            addrI = tv[i].aI; addrD = tv[i].aD; wdataD = tv[i].wd;
            step();
            chk($sformatf("tv%0d.mem_req", i), mem_req, 1);
            chk($sformatf("tv%0d.mem_we", i), mem_we, tv[i].e_own_d & tv[i].we);
            chk($sformatf("tv%0d.mem_addr", i), mem_addr, tv[i].e_own_d ? tv[i].aD : tv[i].aI);
            if (tv[i].e_own_d && tv[i].we)
                chk($sformatf("tv%0d.mem_wdata", i), mem_wdata, tv[i].wd);
            for (int k = 1; k < tv[i].dly; k++) begin
                step();
                chk($sformatf("tv%0d.hold_req", i), mem_req, 1);
                chk($sformatf("tv%0d.early_pulse", i), {ackD, readyD, readyI}, 0);
            end
            mem_ready = 1'b1; mem_rdata = tv[i].md;
            step();
            mem_ready = 1'b0; mem_rdata = {4{32'hBAADF00D}};
            chk($sformatf("tv%0d.req_drop", i), mem_req, 0);
            chk($sformatf("tv%0d.pulse", i), {ackD, readyD, readyI}, tv[i].e_pl);
            chk($sformatf("tv%0d.rdata", i), rdata, tv[i].e_rd);
            chk($sformatf("tv%0d.busy_resp", i), busy, 1);
            reqI = 1'b0; reqD = 1'b0; weD = 1'b0;
            step();
            chk($sformatf("tv%0d.pulse_end", i), {ackD, readyD, readyI}, 0);
            chk($sformatf("tv%0d.idle", i), busy, 0);
            chk($sformatf("tv%0d.rdata_hold", i), rdata, tv[i].e_rd);
        end

        // Both held after reset: D, I, D with an idle gap between grants
        reset = 1'b0; step(); reset = 1'b1;
        exp_order[0] = 26'h0000200; exp_order[1] = 26'h0000100; exp_order[2] = 26'h0000200;
        reqI = 1'b1; reqD = 1'b1; weD = 1'b0; addrI = 26'h0000100; addrD = 26'h0000200;
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("rr%0d.addr", n), mem_addr, exp_order[n]);
            chk($sformatf("rr%0d.req", n), mem_req, 1);
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            chk($sformatf("rr%0d.pulse", n), {ackD, readyD, readyI}, (exp_order[n] == 26'h0000200) ? 3'b010 : 3'b001);
            step();
            chk($sformatf("rr%0d.gap", n), mem_req, 0);
        end
        reqI = 1'b0; reqD = 1'b0;
        step(); step();

        // Flush: request drops right after grant, transaction still completes
        reqI = 1'b1; addrI = 26'h0000055;
        step();
        reqI = 1'b0;
        step();
        chk("flush.req", mem_req, 1);
        mem_ready = 1'b1; mem_rdata = {4{32'h600DCAFE}};
        step();
        mem_ready = 1'b0;
        chk("flush.readyI", readyI, 1);
        chk("flush.rdata", rdata, {4{32'h600DCAFE}});
        step();
        chk("flush.idle", busy, 0);
        chk("flush.pulse_end", readyI, 0);

        // mem_ready while IDLE is ignored
        mem_ready = 1'b1; mem_rdata = {4{32'h13572468}};
        step();
        mem_ready = 1'b0;
        chk("stray.pulses", {ackD, readyD, readyI}, 0);
        chk("stray.rdata", rdata, {4{32'h600DCAFE}});
        chk("stray.busy", busy, 0);

        // Timeout: err from cycle 256, busy held; then reset mid-ISSUE
        reqD = 1'b1; weD = 1'b0; addrD = 26'h0ABCDEF;
        step();
        for (int k = 1; k <= 260; k++) begin
            chk($sformatf("to.err@%0d", k), err, (k >= 256) ? 1'b1 : 1'b0);
            chk($sformatf("to.busy@%0d", k), busy, 1);
            if (k < 260) step();
        end
        reset = 1'b0;
        step();
        chk("to.rst_req", mem_req, 0);
        chk("to.rst_err", err, 0);
        chk("to.rst_busy", busy, 0);
        reqD = 1'b0; reset = 1'b1;
        step();

        // Randomised traffic against a transaction-level reference
        m_open = 0; m_resp = 0; m_last_d = 0; m_own_d = 0; m_we = 0; m_wait = 0;
        e_req = 0; e_we = 0; e_busy = 0; e_pl = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (e_pl[0]) reqI = 1'b0;
            else if (!reqI && $urandom_range(0, 2) == 0) begin
                reqI = 1'b1; addrI = AW'($urandom);
            end
            if (e_pl[1] || e_pl[2]) reqD = 1'b0;
            else if (!reqD && $urandom_range(0, 2) == 0) begin
                reqD = 1'b1; weD = 1'($urandom); addrD = AW'($urandom);
                wdataD = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_ready = 1'b0;
            if (m_open && (m_wait >= 6 || $urandom_range(0, 2) == 0)) mem_ready = 1'b1;
            else if (!m_open && $urandom_range(0, 7) == 0) mem_ready = 1'b1;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};

            e_pl = 3'b000;
            if (m_open) begin
                if (mem_ready) begin
                    m_open = 0; m_resp = 1; e_req = 0;
                    if (!m_we) e_rdata = mem_rdata;
                    e_pl = m_own_d ? (m_we ? 3'b100 : 3'b010) : 3'b001;
                end else begin
                    m_wait++;
                end
            end else if (m_resp) begin
                m_resp = 0; e_busy = 0;
            end else if (reqI || reqD) begin
                m_own_d  = (reqI && reqD) ? !m_last_d : reqD;
                m_last_d = m_own_d;
                m_we     = m_own_d & weD;
                e_req = 1; e_busy = 1; e_we = m_we;
                e_addr = m_own_d ? addrD : addrI;
                e_wdata = wdataD;
                m_open = 1; m_wait = 0;
            end
            step();
            chk("rnd.mem_req", mem_req, e_req);
            chk("rnd.busy", busy, e_busy);
            chk("rnd.pulses", {ackD, readyD, readyI}, e_pl);
            chk("rnd.rdata", rdata, e_rdata);
            chk("rnd.err", err, 0);
            if (e_req) begin
                chk("rnd.mem_addr", mem_addr, e_addr);
                chk("rnd.mem_we", mem_we, e_we);
                if (e_we) chk("rnd.mem_wdata", mem_wdata, e_wdata);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
